// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - RV64 instruction fetch with credit-limited requests and redirect flush
//
// Sequential fetch PC generator feeding a pipelined instruction memory. Returned
// words are queued with their PCs in an in-order FIFO and presented to decode.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     taken branch/jump: flush and restart fetch
//   imem_req_valid/ready/addr       request channel to instruction memory
//   imem_resp_valid/data            in-order response channel (never stalls)
//   inst_valid/ready, inst, inst_pc FIFO head to decode

module inst_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] outstanding, occ, drop_cnt, drop_next;
    logic [63:0]   fetch_pc;
    logic [AW-1:0] wr_ptr, rd_ptr, pc_wr_ptr, pc_rd_ptr;
    logic [31:0]   data_mem    [DEPTH];
    logic [63:0]   inst_pc_mem [DEPTH];
    logic [63:0]   req_pc_mem  [DEPTH];
    logic          accept, resp_live, pop;
    logic [CW:0]   credit_used;

    // Every accepted request reserves a FIFO slot, so responses can never overflow.
    assign credit_used    = {1'b0, outstanding} + {1'b0, occ};
    assign imem_req_valid = rstn && (state == RUN) && !redirect_valid
                            && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response in a redirect cycle, or while stale ones remain, is discarded.
    assign resp_live  = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
    assign inst_valid = (occ != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_valid ? data_mem[rd_ptr]    : '0;
    assign inst_pc    = inst_valid ? inst_pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
        end
    end

    // outstanding only counts live requests; on redirect they all move into
    // drop_cnt, so stale responses are accounted for there and nowhere else.
    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        if (redirect_valid) begin
            drop_next  = drop_cnt + outstanding - CW'(imem_resp_valid);
            state_next = (drop_next != '0) ? FLUSH : RUN;
        end else if (imem_resp_valid && (drop_cnt != '0)) begin
            drop_next = drop_cnt - CW'(1);
            if (drop_next == '0) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= PC_RESET;
            outstanding <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pc_wr_ptr   <= '0;
            pc_rd_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[63:2], 2'b00};
            outstanding <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pc_wr_ptr   <= '0;
            pc_rd_ptr   <= '0;
        end else begin
            if (accept) begin
                fetch_pc  <= fetch_pc + 64'd4;
                pc_wr_ptr <= pc_wr_ptr + AW'(1);
            end
            if (resp_live) begin
                wr_ptr    <= wr_ptr + AW'(1);
                pc_rd_ptr <= pc_rd_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(resp_live);
            occ         <= occ + CW'(resp_live) - CW'(pop);
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    // Responses arrive at least a cycle after acceptance, so the PC slot read
    // here was written in an earlier cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc_mem[pc_wr_ptr] <= fetch_pc;
        end
        if (resp_live) begin
            data_mem[wr_ptr]    <= imem_resp_data;
            inst_pc_mem[wr_ptr] <= req_pc_mem[pc_rd_ptr];
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit

module tb_inst_fetch_unit;
    localparam logic [63:0] PC_RESET = 64'h0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    always #5 clk = ~clk;

    inst_fetch_unit #(.DEPTH(4), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rstn(rstn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [63:0] rpc;
        logic [63:0] a0;
        logic [63:0] a1;
    } redir_vec_t;

    exp_t        exp_q[$];
    logic [63:0] mem_q[$];
    logic [63:0] acc_log[$];
    logic [63:0] exp_addr = PC_RESET;
    logic [63:0] first_pop_pc = '0;
    int          checks = 0;
    int          passed = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    bit          hold = 1'b0;
    bit          rand_resp = 1'b0;
    bit          rand_rdy = 1'b0;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Observe the handshakes at mid-cycle, then drive the memory model after the edge.
    task automatic step();
        logic [63:0] a;
        exp_t        e;
        @(negedge clk);
        if (rstn) begin
            if (redirect_valid) begin
                chk("req_idle_on_redirect", 64'(imem_req_valid), 64'd0);
                exp_q.delete();
                acc_log.delete();
                exp_addr = {redirect_pc[63:2], 2'b00};
            end else begin
                if (imem_req_valid) chk("req_addr", imem_req_addr, exp_addr);
                if (imem_req_valid && imem_req_ready) begin
                    exp_q.push_back('{pc: imem_req_addr, data: word_of(imem_req_addr)});
                    mem_q.push_back(imem_req_addr);
                    acc_log.push_back(imem_req_addr);
                    exp_addr = exp_addr + 64'd4;
                    n_acc++;
                end
                if (inst_valid && inst_ready) begin
                    if (n_pop == 0) first_pop_pc = inst_pc;
                    n_pop++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected_inst actual_pc=%h required=none", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        if (inst_pc === e.pc && inst === e.data) passed++;
                        else $display("FAIL sb_inst actual=%h/%h required=%h/%h",
                                      inst_pc, inst, e.pc, e.data);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (!hold && mem_q.size() > 0 && (!rand_resp || $urandom_range(0, 2) != 0)) begin
            a = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_of(a);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready = 1'b1;
        hold = 1'b0;
        exp_q.delete();
        mem_q.delete();
        acc_log.delete();
        exp_addr = PC_RESET;
        n_acc = 0;
        n_pop = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        rstn = 1'b1;
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    redir_vec_t vecs[4];
    int         n_out;
    logic [63:0] a;

    initial begin
        vecs[0] = '{rpc: 64'h2003,                a0: 64'h2000,                a1: 64'h2004};
        vecs[1] = '{rpc: 64'hFFFF_FFFF_FFFF_FFFC, a0: 64'hFFFF_FFFF_FFFF_FFFC, a1: 64'h0};
        vecs[2] = '{rpc: 64'h1002,                a0: 64'h1000,                a1: 64'h1004};
        vecs[3] = '{rpc: 64'h8000_0001,           a0: 64'h8000_0000,           a1: 64'h8000_0004};

        // Reset and in-order streaming, then randomised memory/decode back-pressure.
        do_reset();
        inst_ready = 1'b1;
        repeat (25) step();
        chk("t1_first_pc", first_pop_pc, PC_RESET);
        rand_rdy = 1'b1;
        rand_resp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            step();
        end
        rand_rdy = 1'b0;
        rand_resp = 1'b0;
        inst_ready = 1'b1;
        repeat (10) step();

        // Decode stall: credits stop issue at four.
        inst_ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("t2_req_count", 64'(n_acc), 64'd4);
        chk("t2_occ", 64'(dut.occ), 64'd4);
        chk("t2_head_pc", inst_pc, 64'h0);
        chk("t2_req_blocked", 64'(imem_req_valid), 64'd0);
        inst_ready = 1'b1;
        repeat (20) step();
        chk("t2_pops", 64'(n_pop >= 8), 64'd1);

        // Redirect with three requests in flight.
        hold = 1'b1;
        for (int i = 0; i < 20 && mem_q.size() < 3; i++) step();
        chk("t3_outstanding", 64'(mem_q.size()), 64'd3);
        redirect_to(64'h1000);
        chk("t3_drop_cnt", 64'(dut.drop_cnt), 64'd3);
        chk("t3_state_flush", 64'(dut.state), 64'd1);
        hold = 1'b0;
        n_pop = 0;
        for (int i = 0; i < 20 && dut.state != 1'b0; i++) begin
            chk("t3_no_req_in_flush", 64'(imem_req_valid), 64'd0);
            step();
        end
        chk("t3_state_run", 64'(dut.state), 64'd0);
        for (int i = 0; i < 20 && n_pop == 0; i++) step();
        chk("t3_first_pc", first_pop_pc, 64'h1000);
        repeat (10) step();

        // Redirect coinciding with a response and a pop.
        inst_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (inst_valid && mem_q.size() >= 2) break;
            hold = inst_valid;
            step();
        end
        hold = 1'b1;
        chk("t4_fifo_nonempty", 64'(inst_valid), 64'd1);
        n_out = mem_q.size();
        a = mem_q.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_of(a);
        inst_ready = 1'b1;
        redirect_to(64'h3000);
        chk("t4_drop_cnt", 64'(dut.drop_cnt), 64'(n_out - 1));
        chk("t4_inst_cleared", 64'(inst_valid), 64'd0);
        hold = 1'b0;
        n_pop = 0;
        for (int i = 0; i < 30 && n_pop == 0; i++) step();
        chk("t4_first_pc", first_pop_pc, 64'h3000);
        repeat (10) step();

        // Misaligned and wrapping redirect targets.
        foreach (vecs[k]) begin
            redirect_to(vecs[k].rpc);
            for (int i = 0; i < 40 && acc_log.size() < 2; i++) step();
            chk($sformatf("t5_addr0_%0d", k), acc_at(0), vecs[k].a0);
            chk($sformatf("t5_addr1_%0d", k), acc_at(1), vecs[k].a1);
            repeat (6) step();
        end

        // Asynchronous reset in the middle of a burst.
        inst_ready = 1'b0;
        repeat (4) step();
        hold = 1'b1;
        repeat (3) step();
        chk("t6_pre_inst_valid", 64'(inst_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_inst_valid_drop", 64'(inst_valid), 64'd0);
        chk("t6_req_valid_drop", 64'(imem_req_valid), 64'd0);
        imem_resp_valid = 1'b0;
        exp_q.delete();
        mem_q.delete();
        acc_log.delete();
        exp_addr = PC_RESET;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        hold = 1'b0;
        inst_ready = 1'b1;
        n_pop = 0;
        for (int i = 0; i < 10 && acc_log.size() == 0; i++) step();
        chk("t6_resume_pc", acc_at(0), PC_RESET);
        repeat (20) step();
        chk("t6_first_pc", first_pop_pc, PC_RESET);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
